// File: rtl/nn_reg_initiator_if.sv
// Streaming operand/result handshake plus NN register-block bus, grouped for nn_reg_initiator.
interface nn_reg_initiator_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic [31:0] addr;
  logic        wren;
  logic [31:0] wrdata;
  logic [31:0] rddata;
  logic        ack;
  logic        nn_ready;
  logic        busy;
  logic [15:0] done_cnt;

  modport master (
    input  in_valid, in_a, in_b, out_ready, rddata, ack, nn_ready,
    output in_ready, out_valid, out_data, out_err, addr, wren, wrdata, busy, done_cnt
  );

  modport slave (
    output in_valid, in_a, in_b, out_ready, rddata, ack, nn_ready,
    input  in_ready, out_valid, out_data, out_err, addr, wren, wrdata, busy, done_cnt
  );
endinterface

// File: rtl/nn_reg_initiator.sv
// Bus initiator: pops operand pairs from a FIFO, writes them to the NN register block,
// waits for the core's ready pulse, reads RESULT back and presents it on a valid/ready stream.
module nn_reg_initiator #(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst_l,
  nn_reg_initiator_if.master  bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_WR_A, S_WR_B, S_WAIT, S_RD_RES, S_OUT} state_t;

  state_t            state_q, state_d;
  logic [31:0]       fifo_a [FIFO_DEPTH];
  logic [31:0]       fifo_b [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push, pop;
  logic [31:0]       cur_a, cur_b;
  logic              seen_q, seen_d;
  logic [15:0]       timer_q, timer_d;
  logic [31:0]       res_q, res_d;
  logic              err_q, err_d;
  logic [15:0]       done_q;

  assign bus.in_ready  = (count != FULL);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = (state_q == S_IDLE) && (count != '0);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_data  = res_q;
  assign bus.out_err   = err_q;
  assign bus.busy      = (state_q != S_IDLE) || (count != '0);
  assign bus.done_cnt  = done_q;

  // Storage needs no reset: pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= bus.in_a;
      fifo_b[wr_ptr] <= bus.in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      state_q <= S_IDLE;
      cur_a   <= '0;
      cur_b   <= '0;
      seen_q  <= 1'b0;
      timer_q <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        cur_a  <= fifo_a[rd_ptr];
        cur_b  <= fifo_b[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      state_q <= state_d;
      seen_q  <= seen_d;
      timer_q <= timer_d;
      res_q   <= res_d;
      err_q   <= err_d;
      if (state_q == S_OUT && bus.out_ready) done_q <= done_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    timer_d = timer_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (count != '0) begin
          state_d = S_WR_A;
          seen_d  = 1'b0;
        end
      end
      S_WR_A: begin
        if (bus.ack) begin
          state_d = S_WR_B;
        end else begin
          state_d = S_OUT;
          res_d   = '0;
          err_d   = 1'b1;
        end
      end
      S_WR_B: begin
        // A ready pulse can arrive while B is still being written; remember it.
        if (bus.nn_ready) seen_d = 1'b1;
        if (bus.ack) begin
          state_d = S_WAIT;
          timer_d = '0;
        end else begin
          state_d = S_OUT;
          res_d   = '0;
          err_d   = 1'b1;
        end
      end
      S_WAIT: begin
        if (seen_q || bus.nn_ready) begin
          state_d = S_RD_RES;
        end else if (timer_q == TMO_LAST) begin
          state_d = S_OUT;
          res_d   = '0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_RD_RES: begin
        state_d = S_OUT;
        res_d   = bus.ack ? bus.rddata : '0;
        err_d   = !bus.ack;
      end
      S_OUT: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus drive depends on registered state only, so reset removes wren immediately.
  always_comb begin
    bus.addr   = '0;
    bus.wren   = 1'b0;
    bus.wrdata = '0;
    case (state_q)
      S_WR_A: begin
        bus.addr   = BASE_ADDR;
        bus.wren   = 1'b1;
        bus.wrdata = cur_a;
      end
      S_WR_B: begin
        bus.addr   = BASE_ADDR + 32'h04;
        bus.wren   = 1'b1;
        bus.wrdata = cur_b;
      end
      S_RD_RES: bus.addr = BASE_ADDR + 32'h30;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nn_reg_initiator.sv
// Bench for nn_reg_initiator: register-block stub, transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_nn_reg_initiator;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] A_ADDR = BASE;
  localparam logic [31:0] B_ADDR = BASE + 32'h04;
  localparam logic [31:0] R_ADDR = BASE + 32'h30;
  localparam int          DEPTH  = 4;
  localparam int          TMO    = 8;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int   cyc = 0;
  int   t_push = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        ack_a_ok, ack_b_ok, ack_r_ok;
  logic        res_ovr_en;
  logic [31:0] res_ovr;
  logic [31:0] reg_a, reg_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nn_reg_initiator_if bus();

  nn_reg_initiator #(
    .BASE_ADDR(BASE),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_l(rst_l),
    .bus(bus)
  );

  function automatic logic [31:0] res_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic ovr_en, input logic [31:0] ovr);
    if (ovr_en) return ovr;
    return {a[15:0] ^ b[31:16], a[31:16] + b[15:0]};
  endfunction

  // Register-block stub: combinational ack/rddata, writes captured on the closing edge.
  always_comb begin
    bus.ack = (bus.addr == A_ADDR && ack_a_ok) || (bus.addr == B_ADDR && ack_b_ok) ||
              (bus.addr == R_ADDR && ack_r_ok);
    bus.rddata = (bus.addr == R_ADDR) ? res_fn(reg_a, reg_b, res_ovr_en, res_ovr) : 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (bus.wren && bus.ack) begin
      if (bus.addr == A_ADDR) reg_a <= bus.wrdata;
      if (bus.addr == B_ADDR) reg_b <= bus.wrdata;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is a script indexed by k = cycles since its pop.
  // k=1 write A, k=2 write B, then waiting until ready/timeout, a read cycle, then output.
  pair_t       mq[$];
  bit          m_act, m_seen, m_err;
  int          m_k, m_rd_at, m_out_at;
  logic [31:0] m_ca, m_cb, m_data;
  logic [15:0] m_done;

  task automatic m_clear();
    mq.delete();
    m_act = 0; m_seen = 0; m_err = 0; m_k = 0; m_rd_at = -1; m_out_at = -1;
    m_data = '0; m_done = '0;
  endtask

  task automatic m_abort(input int at);
    m_out_at = at; m_err = 1; m_data = '0;
  endtask

  task automatic m_step();
    pair_t p;
    bit    take, in_out;
    take   = bus.in_valid && (mq.size() != DEPTH);
    in_out = m_out_at > 0 && m_k >= m_out_at;
    if (m_act) begin
      if (in_out) begin
        if (bus.out_ready) begin m_act = 0; m_done = m_done + 16'd1; end
      end else if (m_k == 1) begin
        if (!ack_a_ok) m_abort(2);
      end else if (m_k == 2) begin
        if (bus.nn_ready) m_seen = 1;
        if (!ack_b_ok) m_abort(3);
      end else if (m_rd_at > 0 && m_k == m_rd_at) begin
        m_err  = !ack_r_ok;
        m_data = ack_r_ok ? res_fn(m_ca, m_cb, res_ovr_en, res_ovr) : '0;
        m_out_at = m_k + 1;
      end else if (m_seen || bus.nn_ready) begin
        m_rd_at = m_k + 1;
      end else if (m_k - 3 == TMO - 1) begin
        m_abort(m_k + 1);
      end
      if (m_act) m_k++;
    end else if (mq.size() != 0) begin
      p = mq.pop_front();
      m_ca = p.a; m_cb = p.b; m_seen = 0; m_act = 1;
      m_k = 1; m_rd_at = -1; m_out_at = -1;
    end
    if (take) mq.push_back({bus.in_a, bus.in_b});
  endtask

  always @(negedge clk) begin
    bit          in_out, ev;
    logic [31:0] ea, ed;
    logic        ew;
    if (!rst_l) m_clear();
    in_out = m_act && m_out_at > 0 && m_k >= m_out_at;
    ea = '0; ed = '0; ew = 1'b0;
    if (m_act && !in_out) begin
      if (m_k == 1) begin ea = A_ADDR; ew = 1'b1; ed = m_ca; end
      else if (m_k == 2) begin ea = B_ADDR; ew = 1'b1; ed = m_cb; end
      else if (m_rd_at > 0 && m_k == m_rd_at) ea = R_ADDR;
    end
    ev = in_out;
    chk("addr", bus.addr, ea);
    chk("wren", 32'(bus.wren), 32'(ew));
    chk("wrdata", bus.wrdata, ed);
    chk("out_valid", 32'(bus.out_valid), 32'(ev));
    chk("in_ready", 32'(bus.in_ready), 32'(mq.size() != DEPTH));
    chk("busy", 32'(bus.busy), 32'(m_act || mq.size() != 0));
    chk("done_cnt", 32'(bus.done_cnt), 32'(m_done));
    if (ev) begin
      chk("out_data", bus.out_data, m_data);
      chk("out_err", 32'(bus.out_err), 32'(m_err));
    end
    if (rst_l) m_step();
  end

  task automatic push1(input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    t_push = cyc;
  endtask

  task automatic wait_out(input string nm, output int lat);
    int n = 0;
    while (!bus.out_valid && n < 60) begin @(posedge clk); #1; n++; end
    lat = cyc - t_push;
    n_cmp++;
    if (!bus.out_valid) begin
      n_bad++;
      $display("FAIL %s: out_valid got 0 within 60 cycles, required 1", nm);
    end
  endtask

  task automatic step_done(input string nm, input logic [15:0] exp);
    @(posedge clk); #1;
    chk(nm, 32'(bus.done_cnt), 32'(exp));
  endtask

  initial begin
    int          lat, got, n, seen_ov;
    logic [31:0] pa [5];
    logic [31:0] pb [5];
    bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1; bus.nn_ready = 0;
    ack_a_ok = 1; ack_b_ok = 1; ack_r_ok = 1; res_ovr_en = 0; res_ovr = '0;
    reg_a = '0; reg_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    rst_l = 1'b1;
    @(posedge clk); #1;

    // Single pair, ready pulse in the second WAIT cycle.
    res_ovr_en = 1; res_ovr = 32'h4120_0000;
    push1(32'h4080_0000, 32'h3f80_0000);
    repeat (4) @(posedge clk);
    #1 bus.nn_ready = 1;
    @(posedge clk); #1 bus.nn_ready = 0;
    wait_out("single_wait", lat);
    chk("single_lat", lat, 6);
    chk("single_data", bus.out_data, 32'h4120_0000);
    chk("single_err", 32'(bus.out_err), 32'd0);
    chk("single_reg_a", reg_a, 32'h4080_0000);
    chk("single_reg_b", reg_b, 32'h3f80_0000);
    step_done("single_done", 16'd1);
    res_ovr_en = 0;

    // Ready only during WR_B.
    push1(32'h1234_5678, 32'h9abc_def0);
    repeat (2) @(posedge clk);
    #1 bus.nn_ready = 1;
    @(posedge clk); #1 bus.nn_ready = 0;
    wait_out("early_wait", lat);
    chk("early_lat", lat, 5);
    chk("early_data", bus.out_data, {16'h5678 ^ 16'h9abc, 16'h1234 + 16'hdef0});
    chk("early_err", 32'(bus.out_err), 32'd0);
    step_done("early_done", 16'd2);

    // No ack on OPERAND_B.
    ack_b_ok = 0;
    push1(32'h1111_1111, 32'h2222_2222);
    wait_out("noack_wait", lat);
    chk("noack_lat", lat, 3);
    chk("noack_data", bus.out_data, 32'h0);
    chk("noack_err", 32'(bus.out_err), 32'd1);
    step_done("noack_done", 16'd3);
    ack_b_ok = 1;

    // Timeout: ready never arrives.
    push1(32'h3333_3333, 32'h4444_4444);
    wait_out("tmo_wait", lat);
    chk("tmo_lat", lat, 3 + TMO);
    chk("tmo_data", bus.out_data, 32'h0);
    chk("tmo_err", 32'(bus.out_err), 32'd1);
    step_done("tmo_done", 16'd4);

    // Back-pressure: five pairs accepted, then full.
    bus.out_ready = 0; bus.nn_ready = 1;
    for (int i = 0; i < 5; i++) begin
      pa[i] = $urandom; pb[i] = $urandom;
      bus.in_valid = 1; bus.in_a = pa[i]; bus.in_b = pb[i];
      @(posedge clk); #1;
    end
    bus.in_valid = 0;
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1 bus.out_ready = 1;
    got = 0;
    for (int c = 0; c < 100 && got < 5; c++) begin
      if (bus.out_valid) begin
        chk("bp_order", bus.out_data, res_fn(pa[got], pb[got], 1'b0, '0));
        got++;
      end
      @(posedge clk); #1;
    end
    chk("bp_count", got, 5);
    bus.nn_ready = 0;

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      bus.in_valid  = ($urandom_range(0, 1) == 1);
      bus.in_a      = $urandom;
      bus.in_b      = $urandom;
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.nn_ready  = ($urandom_range(0, 3) == 0);
      ack_a_ok      = ($urandom_range(0, 9) != 0);
      ack_b_ok      = ($urandom_range(0, 9) != 0);
      ack_r_ok      = ($urandom_range(0, 9) != 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 0; bus.out_ready = 1; ack_a_ok = 1; ack_b_ok = 1; ack_r_ok = 1;
    n = 0;
    while (bus.busy && n < 500) begin
      bus.nn_ready = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1; n++;
    end
    bus.nn_ready = 0;
    chk("drain_busy", 32'(bus.busy), 32'd0);

    // Reset while waiting with two pairs queued.
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1; bus.in_a = $urandom; bus.in_b = $urandom;
      @(posedge clk); #1;
    end
    bus.in_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst_l = 1'b0;
    #1;
    chk("rst_mid_wren", 32'(bus.wren), 32'd0);
    chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_done", 32'(bus.done_cnt), 32'd0);
    chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1 rst_l = 1'b1;
    seen_ov = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.out_valid || bus.busy) seen_ov++;
      @(posedge clk); #1;
    end
    chk("post_rst_quiet", seen_ov, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
